move_sequencer: RTL

MOVE_SEQUENCER -- requirements
Module: move_sequencer

---
 rtl/move_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/move_sequencer.sv
// move_sequencer: queues face-turn codes from the solver and issues them one
// at a time to the actuator, waiting for an ack and a settle gap between moves.
// Optional feature macro: MOVE_SEQ_TIMEOUT_EN (per-move ack timeout -> ERROR).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for start
// ISSUE    | popping FIFO head into move_code
// WAIT_ACK | move_valid high, waiting for a synchronized ack rising edge
// SETTLE   | idle gap after an acknowledged move
// DONE     | one-cycle done pulse
// ERROR    | ack timeout, held until abort or reset
module move_sequencer #(
    parameter int DEPTH          = 16,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_valid,
    input  logic [3:0]               push_move,
    output logic                     push_ready,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     ack,
    output logic [3:0]               move_code,
    output logic                     move_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic                     bad_code,
    output logic [7:0]               moves_done,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef MOVE_SEQ_TIMEOUT_EN
    localparam int TMR_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
`else
    localparam int TMR_MAX = SETTLE_CYCLES;
`endif
    // Timer only ever holds load values up to TMR_MAX-1.
    localparam int TW = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
`ifdef MOVE_SEQ_TIMEOUT_EN
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
`else
    localparam logic [TW-1:0] TIMEOUT_LOAD = '0;
`endif

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_ACK, SETTLE, DONE, ERROR
    } state_t;

    state_t          state;
    logic [3:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            ready_en;
    logic            ack_s1, ack_s2, ack_s3;
    logic [TW-1:0]   timer;
    logic            code_legal;
    logic            push_fire;
    logic            wr_en;
    logic            pop;
    logic            ack_rise;
    logic            timeout_hit;

    // Codes 6,7,E,F have face bits 2:1 == 2'b11 and are illegal.
    assign code_legal = (push_move[2:1] != 2'b11);
    assign push_ready = ready_en && (count != CW'(DEPTH));
    assign push_fire  = push_valid && push_ready && !abort;
    assign wr_en      = push_fire && code_legal;
    assign pop        = (state == ISSUE) && !abort;
    assign ack_rise   = ack_s2 && !ack_s3;
    assign fifo_count = count;

`ifdef MOVE_SEQ_TIMEOUT_EN
    assign timeout_hit = (state == WAIT_ACK) && !ack_rise && (timer == '0);

    // Sticky timeout flag, cleared only by abort or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           error <= 1'b0;
        else if (abort)       error <= 1'b0;
        else if (timeout_hit) error <= 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
`endif

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_move;
    end

    // FIFO pointers and occupancy, flushed by abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_en) - CW'(pop);
        end
    end

    // push_ready held low through reset and released on the first clock after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // Sticky flag for dropped illegal codes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        bad_code <= 1'b0;
        else if (push_fire && !code_legal) bad_code <= 1'b1;
    end

    // Two-flop synchronizer for ack plus a third flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_s1 <= 1'b0;
            ack_s2 <= 1'b0;
            ack_s3 <= 1'b0;
        end else begin
            ack_s1 <= ack;
            ack_s2 <= ack_s1;
            ack_s3 <= ack_s2;
        end
    end

    // Sequencer FSM with registered outputs and a shared settle/timeout down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            move_code  <= 4'h0;
            move_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            moves_done <= 8'd0;
            timer      <= '0;
        end else if (abort) begin
            state      <= IDLE;
            move_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timer      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            moves_done <= 8'd0;
                            busy       <= 1'b1;
                            state      <= ISSUE;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    move_code  <= mem[rd_ptr];
                    move_valid <= 1'b1;
                    timer      <= TIMEOUT_LOAD;
                    state      <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (ack_rise) begin
                        move_valid <= 1'b0;
                        if (moves_done != 8'hFF) moves_done <= moves_done + 8'd1;
                        timer      <= SETTLE_LOAD;
                        state      <= SETTLE;
                    end else if (timeout_hit) begin
                        move_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= ERROR;
                    end else if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end
                end
                SETTLE: begin
                    if (timer == '0) begin
                        if (count != '0) begin
                            state <= ISSUE;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                ERROR: begin
                    move_valid <= 1'b0;
                    busy       <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
